// File: rtl/decode_fwd.sv
// Decode stage: resolves operands A/B with EX/WB forwarding, registers them for
// execute, and inserts one bubble per cycle while a load-use hazard is pending.
module decode_fwd #(
    parameter int DATA_W = 32,
    parameter int NREG   = 14,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instr_d,
    input  logic                   valid_d,
    input  logic [NREG*DATA_W-1:0] rf_flat,
    input  logic [DATA_W-1:0]      pc,
    input  logic [DATA_W-1:0]      overflow,
    input  logic                   ex_wr_en,
    input  logic [3:0]             ex_wr_idx,
    input  logic [DATA_W-1:0]      ex_wr_data,
    input  logic                   ex_is_load,
    input  logic                   wb_wr_en,
    input  logic [3:0]             wb_wr_idx,
    input  logic [DATA_W-1:0]      wb_wr_data,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic [DATA_W-1:0]      Aval,
    output logic [DATA_W-1:0]      Bval,
    output logic [31:0]            instr_x,
    output logic                   valid_x,
    output logic                   dec_stall,
    output logic [CNT_W-1:0]       bubble_cnt
);

    localparam logic [4:0] NREG5 = 5'(NREG);

    logic        imb;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [13:0] imm;
    logic        ra_gen;
    logic        rb_gen;
    logic        ex_gen;
    logic        hazard;

    logic [DATA_W-1:0] a_res;
    logic [DATA_W-1:0] b_res;

    logic [DATA_W-1:0] aval_q, aval_d;
    logic [DATA_W-1:0] bval_q, bval_d;
    logic [31:0]       instr_q, instr_nx;
    logic              valid_q, valid_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign imb = instr_d[31];
    assign ra  = instr_d[30:27];
    assign rb  = instr_d[26:23];
    assign imm = instr_d[26:13];

    assign ra_gen = ({1'b0, ra} < NREG5);
    assign rb_gen = ({1'b0, rb} < NREG5);
    assign ex_gen = ({1'b0, ex_wr_idx} < NREG5);

    // EX is younger than WB, so it is checked last and overrides; a pending
    // load in EX is never forwarded (the hazard path covers that case).
    function automatic logic [DATA_W-1:0] fwd_val(input logic [3:0] k);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (k == 4'(i)) v = rf_flat[i*DATA_W +: DATA_W];
        end
        if (wb_wr_en && wb_wr_idx == k) v = wb_wr_data;
        if (ex_wr_en && ex_wr_idx == k && !ex_is_load) v = ex_wr_data;
        return v;
    endfunction

    always_comb begin
        a_res = '0;
        if (ra == 4'd14)      a_res = pc;
        else if (ra == 4'd15) a_res = overflow;
        else if (ra_gen)      a_res = fwd_val(ra);

        b_res = '0;
        if (imb)         b_res = {{(DATA_W-14){imm[13]}}, imm};
        else if (rb_gen) b_res = fwd_val(rb);
    end

    assign hazard = valid_d & ex_wr_en & ex_is_load & ex_gen &
                    ((ex_wr_idx == ra) | (!imb & (ex_wr_idx == rb)));

    // Handshake: dec_stall high means decode did not consume instr_d this
    // cycle and fetch must present the same instr_d/valid_d again.
    assign dec_stall = !flush & (stall_in | hazard);

    always_comb begin
        aval_d   = aval_q;
        bval_d   = bval_q;
        instr_nx = instr_q;
        valid_nx = valid_q;
        cnt_d    = cnt_q;
        if (flush) begin
            instr_nx = '0;
            valid_nx = 1'b0;
        end else if (stall_in) begin
            cnt_d = cnt_q;
        end else if (hazard) begin
            instr_nx = '0;
            valid_nx = 1'b0;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end else if (!valid_d) begin
            instr_nx = '0;
            valid_nx = 1'b0;
        end else begin
            aval_d   = a_res;
            bval_d   = b_res;
            instr_nx = instr_d;
            valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aval_q  <= '0;
            bval_q  <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            aval_q  <= aval_d;
            bval_q  <= bval_d;
            instr_q <= instr_nx;
            valid_q <= valid_nx;
            cnt_q   <= cnt_d;
        end
    end

    assign Aval       = aval_q;
    assign Bval       = bval_q;
    assign instr_x    = instr_q;
    assign valid_x    = valid_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_decode_fwd.sv
// Bench for decode_fwd: table of single-cycle decode vectors, then hand-written
// sequences for load-use, stall, flush, reset, saturation and small NREG.
module tb_decode_fwd;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     instr_d;
    logic            valid_d;
    logic [14*W-1:0] rf_flat;
    logic [W-1:0]    pc, overflow;
    logic            ex_wr_en, ex_is_load, wb_wr_en;
    logic [3:0]      ex_wr_idx, wb_wr_idx;
    logic [W-1:0]    ex_wr_data, wb_wr_data;
    logic            stall_in, flush;

    logic [W-1:0]  aval, bval, aval8, bval8, avalc, bvalc;
    logic [31:0]   instr_x, instr_x8, instr_xc;
    logic          valid_x, valid_x8, valid_xc;
    logic          dec_stall, dec_stall8, dec_stallc;
    logic [15:0]   bubble_cnt, bubble_cnt8;
    logic [1:0]    bubble_cntc;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    decode_fwd u_dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .rf_flat(rf_flat),
        .pc(pc), .overflow(overflow), .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx),
        .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load), .wb_wr_en(wb_wr_en),
        .wb_wr_idx(wb_wr_idx), .wb_wr_data(wb_wr_data), .stall_in(stall_in), .flush(flush),
        .Aval(aval), .Bval(bval), .instr_x(instr_x), .valid_x(valid_x),
        .dec_stall(dec_stall), .bubble_cnt(bubble_cnt)
    );

    decode_fwd #(.NREG(8)) u_n8 (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .rf_flat(rf_flat[8*W-1:0]),
        .pc(pc), .overflow(overflow), .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx),
        .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load), .wb_wr_en(wb_wr_en),
        .wb_wr_idx(wb_wr_idx), .wb_wr_data(wb_wr_data), .stall_in(stall_in), .flush(flush),
        .Aval(aval8), .Bval(bval8), .instr_x(instr_x8), .valid_x(valid_x8),
        .dec_stall(dec_stall8), .bubble_cnt(bubble_cnt8)
    );

    decode_fwd #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .rf_flat(rf_flat),
        .pc(pc), .overflow(overflow), .ex_wr_en(ex_wr_en), .ex_wr_idx(ex_wr_idx),
        .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load), .wb_wr_en(wb_wr_en),
        .wb_wr_idx(wb_wr_idx), .wb_wr_data(wb_wr_data), .stall_in(stall_in), .flush(flush),
        .Aval(avalc), .Bval(bvalc), .instr_x(instr_xc), .valid_x(valid_xc),
        .dec_stall(dec_stallc), .bubble_cnt(bubble_cntc)
    );

    typedef struct {
        logic [31:0] instr;
        logic        ex_en;
        logic [3:0]  ex_idx;
        logic [W-1:0] ex_data;
        logic        ex_load;
        logic        wb_en;
        logic [3:0]  wb_idx;
        logic [W-1:0] wb_data;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] mk(input logic imb, input logic [3:0] ra, input logic [13:0] imm);
        return {imb, ra, imm, 5'h0A, 4'h6, 3'b101, 1'b1};
    endfunction

    function automatic logic [13:0] rbf(input logic [3:0] rb);
        return {rb, 10'h000};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic ee, input logic [3:0] ei,
                         input logic [W-1:0] ed, input logic el, input logic we,
                         input logic [3:0] wi, input logic [W-1:0] wd);
        instr_d = ins; valid_d = 1'b1;
        ex_wr_en = ee; ex_wr_idx = ei; ex_wr_data = ed; ex_is_load = el;
        wb_wr_en = we; wb_wr_idx = wi; wb_wr_data = wd;
    endtask

    logic [31:0] lu_instr;

    initial begin
        rst = 1'b1; instr_d = '0; valid_d = 1'b0; stall_in = 1'b0; flush = 1'b0;
        pc = 32'h40; overflow = 32'h9;
        ex_wr_en = 1'b0; ex_wr_idx = '0; ex_wr_data = '0; ex_is_load = 1'b0;
        wb_wr_en = 1'b0; wb_wr_idx = '0; wb_wr_data = '0;
        for (int i = 0; i < 14; i++) rf_flat[i*W +: W] = 32'h100 + 32'(i);
        rf_flat[3*W +: W] = 32'h11;
        rf_flat[5*W +: W] = 32'h1;

        vecs[0] = '{mk(1, 3, 14'h3FFF), 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'hFFFFFFFF};
        vecs[1] = '{mk(0, 5, rbf(5)), 1, 5, 32'h3, 0, 1, 5, 32'h2, 32'h3, 32'h3};
        vecs[2] = '{mk(0, 5, rbf(5)), 0, 5, 32'h3, 0, 1, 5, 32'h2, 32'h2, 32'h2};
        vecs[3] = '{mk(0, 5, rbf(5)), 0, 5, 32'h3, 0, 0, 5, 32'h2, 32'h1, 32'h1};
        vecs[4] = '{mk(1, 14, 14'h0123), 0, 0, 0, 0, 0, 0, 0, 32'h40, 32'h123};
        vecs[5] = '{mk(0, 15, rbf(14)), 0, 0, 0, 0, 0, 0, 0, 32'h9, 32'h0};
        vecs[6] = '{mk(1, 1, 14'h1C05), 1, 7, 32'hDEAD, 1, 0, 0, 0, 32'h101, 32'h1C05};
        vecs[7] = '{mk(0, 12, rbf(13)), 1, 12, 32'hAAAA, 0, 1, 13, 32'hBBBB, 32'hAAAA, 32'hBBBB};
        vecs[8] = '{mk(1, 13, 14'h2000), 0, 0, 0, 0, 0, 0, 0, 32'h10D, 32'hFFFFE000};
        vecs[9] = '{mk(0, 0, rbf(1)), 1, 4, 32'h77, 1, 1, 0, 32'h55, 32'h55, 32'h101};

        tick(); tick();
        chk("reset_aval", aval, 0);
        chk("reset_bval", bval, 0);
        chk("reset_instr_x", instr_x, 0);
        chk("reset_valid_x", valid_x, 0);
        chk("reset_cnt", bubble_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].instr, vecs[i].ex_en, vecs[i].ex_idx, vecs[i].ex_data, vecs[i].ex_load,
                  vecs[i].wb_en, vecs[i].wb_idx, vecs[i].wb_data);
            exp_q.push_back(vecs[i].exp_a);
            exp_q.push_back(vecs[i].exp_b);
            #1;
            chk($sformatf("vec%0d_stall", i), dec_stall, 0);
            tick();
            chk($sformatf("vec%0d_aval", i), aval, exp_q.pop_front());
            chk($sformatf("vec%0d_bval", i), bval, exp_q.pop_front());
            chk($sformatf("vec%0d_instr_x", i), instr_x, vecs[i].instr);
            chk($sformatf("vec%0d_valid_x", i), valid_x, 1);
        end

        // Load-use: EX holds a load to r7 and decode reads r7 as B.
        lu_instr = mk(0, 1, rbf(7));
        drive(lu_instr, 1, 7, 32'hDEAD, 1, 0, 0, 0);
        #1;
        chk("lu_stall", dec_stall, 1);
        tick();
        chk("lu_bubble_instr", instr_x, 0);
        chk("lu_bubble_valid", valid_x, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_aval_hold", aval, 32'h55);
        drive(lu_instr, 0, 0, 0, 0, 1, 7, 32'hAB);
        #1;
        chk("lu_stall_clear", dec_stall, 0);
        tick();
        chk("lu_bval_wb", bval, 32'hAB);
        chk("lu_aval", aval, 32'h101);
        chk("lu_valid", valid_x, 1);
        chk("lu_cnt_once", bubble_cnt, 1);

        // Stall for three cycles: everything frozen.
        drive(mk(1, 3, 14'h0001), 0, 0, 0, 0, 0, 0, 0);
        stall_in = 1'b1;
        #1;
        chk("stall_dec_stall", dec_stall, 1);
        tick(); tick(); tick();
        chk("stall_aval", aval, 32'h101);
        chk("stall_bval", bval, 32'hAB);
        chk("stall_instr_x", instr_x, lu_instr);
        chk("stall_valid_x", valid_x, 1);
        stall_in = 1'b0;
        tick();
        chk("unstall_aval", aval, 32'h11);
        chk("unstall_bval", bval, 32'h1);

        // valid_d low produces a bubble without counting.
        valid_d = 1'b0;
        tick();
        chk("novalid_valid_x", valid_x, 0);
        chk("novalid_instr_x", instr_x, 0);
        chk("novalid_aval_hold", aval, 32'h11);
        chk("novalid_cnt", bubble_cnt, 1);

        // Flush during a hazard: flush wins, no stall, no count.
        drive(mk(1, 3, 14'h0001), 1, 3, 32'h5, 1, 0, 0, 0);
        tick();
        flush = 1'b1;
        #1;
        chk("flush_dec_stall", dec_stall, 0);
        tick();
        chk("flush_valid_x", valid_x, 0);
        chk("flush_instr_x", instr_x, 0);
        chk("flush_cnt", bubble_cnt, 2);
        chk("flush_aval_hold", aval, 32'h11);
        flush = 1'b0;

        // Reset while the hazard is still active clears all state.
        rst = 1'b1;
        tick();
        chk("rst_hazard_cnt", bubble_cnt, 0);
        chk("rst_hazard_aval", aval, 0);
        chk("rst_hazard_cnt_c2", bubble_cntc, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt16", bubble_cnt, 5);
        chk("sat_cnt2", bubble_cntc, 3);
        chk("sat_valid_x", valid_x, 0);

        // Small register file: index 9 is not a general register.
        drive(mk(0, 9, rbf(2)), 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("n14_ra9", aval, 32'h109);
        chk("n8_ra9", aval8, 0);
        chk("n8_rb2", bval8, 32'h102);
        drive(mk(0, 9, rbf(2)), 1, 9, 32'h1, 1, 0, 0, 0);
        #1;
        chk("n14_hazard_r9", dec_stall, 1);
        chk("n8_no_hazard_r9", dec_stall8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_fwd.md
# decode_fwd

Parametrised decode stage with operand forwarding and load-use hazard handling. It replaces the plain register-read decode between fetch and execute, and it uses the same 32-bit instruction format. Each cycle it resolves operands A and B from the register file, the pc, the overflow register, the sign-extended immediate, or the EX/WB result buses. It registers the operands and the instruction for execute, and it inserts bubbles on load-use hazards.

## Interface
- DATA_W, 32: operand and register width; must be ≥ 16.
- NREG, 14: number of general registers, 1..14; index 14 = pc, 15 = overflow.
- CNT_W, 16: width of the bubble counter.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_d  in  32  instruction in decode.
  - Fields: Imb[31], Ra[30:27], Imm[26:13], Opc[12:8], Rc[7:4], Cond[3:1], Cmp[0].
  - Rb = [26:23].
- valid_d  in  1  instr_d is a real instruction.
- rf_flat  in  NREG*DATA_W  register file; register i occupies bits [i*DATA_W +: DATA_W].
- pc  in  DATA_W  pc of instr_d.
- overflow  in  DATA_W  overflow register.
- ex_wr_en / ex_wr_idx[3:0] / ex_wr_data[DATA_W]  in  result currently in execute.
- ex_is_load  in  1  EX result is a load; data not yet available.
- wb_wr_en / wb_wr_idx[3:0] / wb_wr_data[DATA_W]  in  result in writeback, committed next edge.
- stall_in  in  1  execute cannot accept; hold.
- flush  in  1  kill the instruction in decode and the execute register.
- Aval, Bval  out  DATA_W  registered operands.
- instr_x  out  32  registered instruction for execute; 0 = bubble.
- valid_x  out  1  instr_x is real.
- dec_stall  out  1  combinational; fetch must hold instr_d/valid_d.
- bubble_cnt  out  CNT_W  count of hazard bubbles.

## Operation
- Source A selection:
  - Ra=14 → pc.
  - Ra=15 → overflow.
  - Ra ≥ NREG (and < 14) → 0.
  - Otherwise: forwarded value or rf.
- Source B selection:
  - Imb=1 → sign-extend Imm[13:0] to DATA_W.
  - Imb=0 and Rb < NREG → forwarded value or rf.
  - Imb=0 and Rb ≥ NREG → 0; pc and overflow are not B sources.
- Forward priority for a general register index k:
  1. EX, when ex_wr_en & ex_wr_idx==k & !ex_is_load.
  2. WB, when wb_wr_en & wb_wr_idx==k.
  3. rf_flat[k].
  - Indices ≥ NREG never forward.
- Load-use hazard:
  - hazard = valid_d & ex_wr_en & ex_is_load & ex_wr_idx < NREG & (ex_wr_idx==Ra | (!Imb & ex_wr_idx==Rb)).
  - Ra ≥ NREG never matches.
- dec_stall = !flush & (stall_in | hazard).
- Register update priority per edge:
  1. rst: Aval=0, Bval=0, instr_x=0, valid_x=0, bubble_cnt=0.
  2. flush: instr_x=0, valid_x=0; Aval and Bval hold; bubble_cnt unchanged.
  3. stall_in: all outputs hold; bubble_cnt unchanged, even if hazard is also true.
  4. hazard: instr_x=0, valid_x=0; Aval and Bval hold; bubble_cnt += 1, saturating at 2^CNT_W−1.
  5. valid_d=0: instr_x=0, valid_x=0; Aval and Bval hold.
  6. Otherwise: Aval and Bval = resolved values, instr_x=instr_d, valid_x=1.
- Opc, Rc, Cond and Cmp are passed through untouched inside instr_x.

## Timing
- Latency is 1 cycle: operands resolved in cycle n appear on Aval/Bval in n+1.
- Forwarding and hazard detection are combinational, sampled at the edge that captures.
- A load hazard lasts exactly 1 cycle when stall_in stays low:
  - Next cycle the load is in WB and WB forwarding supplies the value.
  - instr_d stays valid because dec_stall held fetch.
- EX and WB writing the same index: the EX value wins (younger).
- Hazard together with flush: flush wins; dec_stall=0; no count.
- rst mid-stall or mid-hazard: outputs clear the next edge; no residual state.
- The only state beyond the pipeline register is bubble_cnt.

## Test plan
- Reset then basic decode:
  - Stimulus: r3=0x11; instr Ra=3, Imb=1, Imm=0x3FFF.
  - Required: Aval=0x11, Bval=0xFFFFFFFF, valid_x=1 one cycle later.
- Forward priority:
  - Stimulus: Ra=Rb=5, Imb=0, r5=1, WB writes 5 with value 2, EX writes 5 with value 3.
  - Required: Aval=Bval=3.
  - Drop EX → Aval=Bval=2; drop WB → Aval=Bval=1.
- Load-use:
  - Stimulus: EX load to r7; decode Rb=7, Imb=0.
  - Required: dec_stall=1 for 1 cycle; one bubble (instr_x=0); bubble_cnt=1.
  - Then WB supplies 0xAB → Bval=0xAB.
- No false hazard:
  - Stimulus: EX load to r7; decode Imm bits place 7 in the Rb position with Imb=1.
  - Required: no stall; Bval is the sign-extended Imm.
- Special sources:
  - Stimulus: Ra=14 with pc=0x40; then Ra=15 with overflow=0x9.
  - Required: Aval=0x40, then Aval=0x9.
  - With NREG=8, Ra=9 → Aval=0.
- Stall, flush and saturation:
  - stall_in=1 for 3 cycles: outputs frozen.
  - flush during a hazard: valid_x=0, dec_stall=0, no count.
  - CNT_W=2 with 5 hazards: bubble_cnt=3.
